// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
// Request fields are combinational from the master and are held stable until bus_ack.
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: req/ack data-bus transaction, lane handling and MEM/WB register.
// Optional macro MEM_MISALIGN_EN: suppress misaligned accesses and add the misalign_out pulse.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic        reg_wr_in,
  input  logic        mux_reg_wr_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ula_res_in,
  input  logic [31:0] val_B_in,
  input  logic [4:0]  rd_in,
  mem_stage_if.master bus,
  output logic        stall,
  output logic        reg_wr_out,
  output logic        mux_reg_wr_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] ula_res_out,
  output logic [4:0]  rd_out
`ifdef MEM_MISALIGN_EN
  ,
  output logic        misalign_out
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      r_state;
  logic        w_access;
  logic        w_load;
  logic        w_misalign;
  logic        w_go;
  logic [1:0]  w_off;
  logic [31:0] w_load_data;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh_b = rdata >> {off, 3'b000};
    sh_h = rdata >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  assign w_access = mem_rd_in | mem_wr_in;
  assign w_load   = mem_rd_in & ~mem_wr_in;
  assign w_off    = ula_res_in[1:0];

`ifdef MEM_MISALIGN_EN
  assign w_misalign = w_access &
                      (((funct3_in[1:0] == 2'b01) & w_off[0]) |
                       (funct3_in[1] & (w_off != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_go        = w_access & ~w_misalign;
  assign w_load_data = load_ext(funct3_in, w_off, bus.bus_rdata);

  // Reset gates the request directly so it drops even while the held inputs still ask.
  assign bus.bus_req   = ~rst & ((r_state == WAIT) | w_go);
  assign bus.bus_we    = mem_wr_in;
  assign bus.bus_addr  = {ula_res_in[31:2], 2'b00};
  assign bus.bus_be    = lane_be(funct3_in[1:0], w_off);
  assign bus.bus_wdata = store_data(funct3_in[1:0], val_B_in);
  assign stall         = bus.bus_req & ~bus.bus_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_go && !bus.bus_ack) r_state <= WAIT;
        WAIT:    if (bus.bus_ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // MEM/WB boundary: a stalled cycle inserts a bubble by dropping the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_out     <= 1'b0;
      mux_reg_wr_out <= 1'b0;
      mem_data_out   <= 32'h0;
      ula_res_out    <= 32'h0;
      rd_out         <= 5'h0;
    end else if (!stall) begin
      reg_wr_out     <= reg_wr_in & ~w_misalign;
      mux_reg_wr_out <= mux_reg_wr_in;
      mem_data_out   <= (w_load & w_go) ? w_load_data : 32'h0;
      ula_res_out    <= ula_res_in;
      rd_out         <= rd_in;
    end else begin
      reg_wr_out     <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_out <= 1'b0;
    else     misalign_out <= w_misalign & ~stall;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand sequences and
// randomized accesses against a byte-lane arithmetic reference model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in;
  logic [2:0]  funct3_in;
  logic [31:0] ula_res_in, val_B_in;
  logic [4:0]  rd_in;
  logic        stall, reg_wr_out, mux_reg_wr_out;
  logic [31:0] mem_data_out, ula_res_out;
  logic [4:0]  rd_out;
`ifdef MEM_MISALIGN_EN
  logic        misalign_out;
`endif

  int n_chk = 0;
  int n_err = 0;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in),
    .mux_reg_wr_in(mux_reg_wr_in), .funct3_in(funct3_in), .ula_res_in(ula_res_in),
    .val_B_in(val_B_in), .rd_in(rd_in), .bus(bus_if),
    .stall(stall), .reg_wr_out(reg_wr_out), .mux_reg_wr_out(mux_reg_wr_out),
    .mem_data_out(mem_data_out), .ula_res_out(ula_res_out), .rd_out(rd_out)
`ifdef MEM_MISALIGN_EN
    , .misalign_out(misalign_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, valb, rdata;
    logic [3:0]  be;
    logic [31:0] wdata, data;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes and the byte position of the selected lane.
  function automatic int m_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic int m_lane(input logic [2:0] f3, input logic [31:0] a);
    int n = m_bytes(f3);
    int o = int'(a[1:0]);
    return (n == 1) ? o : (n == 2) ? (o / 2) * 2 : 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v = ((1 << m_bytes(f3)) - 1) << m_lane(f3, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n = m_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    int n = m_bytes(f3);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    logic [31:0] v = (rdata >> (8 * m_lane(f3, a))) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] vb, input logic [4:0] rdi);
    mem_rd_in = rd; mem_wr_in = wr; reg_wr_in = rw; mux_reg_wr_in = rd;
    funct3_in = f3; ula_res_in = a; val_B_in = vb; rd_in = rdi;
  endtask

  // One access completed after nwait wait cycles, checked against the model.
  task automatic run_access(input logic rd, input logic wr, input logic rw, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] vb, input logic [31:0] rdata,
                            input logic [4:0] rdi, input int nwait, output int stalls);
    logic acc = rd | wr;
    stalls = 0;
    drive(rd, wr, rw, f3, a, vb, rdi);
    bus_if.bus_rdata = rdata;
    if (acc) begin
      for (int i = 0; i < nwait; i++) begin
        bus_if.bus_ack = 1'b0;
        #1;
        if (stall) stalls++;
        chk("wait_req", bus_if.bus_req, 1'b1);
        tick();
        chk("bubble_reg_wr", reg_wr_out, 1'b0);
      end
    end
    bus_if.bus_ack = 1'b1;
    #1;
    chk("ack_stall", stall, 1'b0);
    chk("req", bus_if.bus_req, acc);
    if (acc) begin
      chk("we", bus_if.bus_we, wr);
      chk("addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
      chk("be", bus_if.bus_be, m_be(f3, a));
      chk("wdata", bus_if.bus_wdata, m_wdata(f3, vb));
    end
    tick();
    bus_if.bus_ack = 1'b0;
    chk("wb_reg_wr", reg_wr_out, rw);
    chk("wb_mux", mux_reg_wr_out, rd);
    chk("wb_data", mem_data_out, (rd && !wr) ? m_load(f3, a, rdata) : 32'h0);
    chk("wb_ula", ula_res_out, a);
    chk("wb_rd", rd_out, rdi);
  endtask

  initial begin
    int st;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;

    //           rd    wr    f3      addr          valb          rdata         be       wdata         data
    vt.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 4'b1100, 32'h0,         32'h0000_BEEF});
    vt.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0,         32'h1234_8001, 4'b0011, 32'h0,         32'hFFFF_8001});
    vt.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_F000, 4'b0010, 32'h0,         32'h0000_00F0});
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF});
    vt.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_00A2, 32'h1234_CAFE, 32'h0,        4'b1100, 32'hCAFE_CAFE, 32'h0});
    vt.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h89AB_CDEF, 32'h0,        4'b1111, 32'h89AB_CDEF, 32'h0});
    vt.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'hFFFF_FFFF, 4'b1111, 32'h1122_3344, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h7F00_0000, 4'b1000, 32'h0,         32'h0000_007F});
`ifndef MEM_MISALIGN_EN
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus_if.bus_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_reg_wr", reg_wr_out, 1'b0);
    chk("rst_data", mem_data_out, 32'h0);
    chk("rst_ula", ula_res_out, 32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait vectors from the table
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rd, vt[i].wr, vt[i].rd & ~vt[i].wr, vt[i].f3, vt[i].addr, vt[i].valb, 5'(i + 1));
      bus_if.bus_rdata = vt[i].rdata;
      bus_if.bus_ack = 1'b1;
      #1;
      chk("tbl_req", bus_if.bus_req, 1'b1);
      chk("tbl_stall", stall, 1'b0);
      chk("tbl_we", bus_if.bus_we, vt[i].wr);
      chk("tbl_addr", bus_if.bus_addr, {vt[i].addr[31:2], 2'b00});
      chk("tbl_be", bus_if.bus_be, vt[i].be);
      if (vt[i].wr) chk("tbl_wdata", bus_if.bus_wdata, vt[i].wdata);
      tick();
      bus_if.bus_ack = 1'b0;
      chk("tbl_data", mem_data_out, vt[i].data);
      chk("tbl_reg_wr", reg_wr_out, vt[i].rd & ~vt[i].wr);
      chk("tbl_rd", rd_out, 5'(i + 1));
    end

    // LB with three wait cycles
    run_access(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd7, 3, st);
    chk("lb_stall_cycles", st, 3);
    chk("lb_data", mem_data_out, 32'hFFFF_FF80);

    // Ack with no request is ignored; the following access still waits
    drive(1'b0, 1'b0, 1'b1, 3'd0, 32'h44, 32'h0, 5'd3);
    bus_if.bus_ack = 1'b1;
    #1;
    chk("idle_ack_req", bus_if.bus_req, 1'b0);
    chk("idle_ack_stall", stall, 1'b0);
    tick();
    run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 5'd9, 2, st);
    chk("after_idle_ack_stalls", st, 2);

    // Back-to-back stores, one wait each, no idle gap
    run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h1111_2222, 32'h0, 5'd0, 1, st);
    chk("sw1_stalls", st, 1);
    run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h3333_4444, 32'h0, 5'd0, 1, st);
    chk("sw2_stalls", st, 1);

`ifdef MEM_MISALIGN_EN
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd5);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("mis_req", bus_if.bus_req, 1'b0);
    chk("mis_stall", stall, 1'b0);
    tick();
    chk("mis_pulse", misalign_out, 1'b1);
    chk("mis_reg_wr", reg_wr_out, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("mis_pulse_end", misalign_out, 1'b0);
`endif

    // Randomized accesses against the model
    for (int i = 0; i < 150; i++) begin
      int kind = int'($urandom_range(0, 3));
      logic [2:0]  f3 = 3'($urandom);
      logic [31:0] a  = $urandom;
      logic rd = (kind == 1) || (kind == 3);
      logic wr = (kind >= 2);
`ifdef MEM_MISALIGN_EN
      if (m_bytes(f3) == 4) a[1:0] = 2'b00;
      else if (m_bytes(f3) == 2) a[0] = 1'b0;
`endif
      run_access(rd, wr, 1'($urandom), f3, a, $urandom, $urandom, 5'($urandom),
                 int'($urandom_range(0, 3)), st);
    end

    // Reset while waiting: request and stall drop immediately, MEM/WB clears
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h0, 5'd12);
    bus_if.bus_ack = 1'b0;
    tick();
    chk("pre_rst_wait_req", bus_if.bus_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus_if.bus_req, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_reg_wr", reg_wr_out, 1'b0);
    chk("mid_rst_mux", mux_reg_wr_out, 1'b0);
    chk("mid_rst_data", mem_data_out, 32'h0);
    chk("mid_rst_ula", ula_res_out, 32'h0);
    chk("mid_rst_rd", rd_out, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
